serial_compare_arbiter: RTL and testbench

Shares one MSB-first serial magnitude-compare engine between two requesters.
- Each requester hands over a parallel operand pair (a, b) through a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The block shifts the pair through the compare engine one bit per cycle, MSB first, with optional early exit on the first differing bit.
- It returns less/eq/greater plus the requester id through a valid/ready result port.
- It sits between parallel producers and the serial compare datapath, and replaces ad-hoc per-client comparators.

---
 rtl/serial_compare_arbiter.sv | 167 ++++++++++++++++
 tb/tb_serial_compare_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_arbiter.sv
// Two-client round-robin front end for a shared MSB-first serial magnitude
// comparator. A granted operand pair is shifted through one bit per cycle.
// The unsigned less/eq/greater result is then held on a valid/ready port
// until the consumer takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrating; the granted requester sees ready and is captured
// SHIFT | examining bit[cnt] of the captured pair each cycle, MSB first
// DONE  | result presented on res_*, waiting for res_ready
module serial_compare_arbiter #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic             res_less,
    output logic             res_eq,
    output logic             res_greater,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             id_q,      id_d;
    logic             last_q,    last_d;
    logic             decided_q, decided_d;
    logic             lt_q,      lt_d;
    logic             gt_q,      gt_d;

    logic grant_vld;
    logic grant_id;
    logic a_bit;
    logic b_bit;
    logic new_diff;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Accept is only offered while idle, so the two readies are mutually exclusive
    always_comb begin
        req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
        req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;
    end

    // Bit pair under examination this cycle; only the first difference decides
    always_comb begin
        a_bit    = a_q[cnt_q];
        b_bit    = b_q[cnt_q];
        new_diff = (a_bit ^ b_bit) & ~decided_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        last_d    = last_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d       = grant_id ? req1_a : req0_a;
                    b_d       = grant_id ? req1_b : req0_b;
                    id_d      = grant_id;
                    last_d    = grant_id;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    gt_d      = 1'b0;
                    cnt_d     = CNT_MAX;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (new_diff) begin
                    decided_d = 1'b1;
                    lt_d      = ~a_bit &  b_bit;
                    gt_d      =  a_bit & ~b_bit;
                end
                // cnt stops at zero rather than wrapping
                if ((cnt_q == '0) || (EARLY_EXIT && new_diff)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; last_q resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            last_q    <= last_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
        end
    end

    // Result port is forced to zero whenever no result is being presented
    always_comb begin
        res_valid   = (state_q == DONE);
        res_id      = res_valid & id_q;
        res_less    = res_valid & lt_q;
        res_greater = res_valid & gt_q;
        res_eq      = res_valid & ~lt_q & ~gt_q;
        busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Bench for serial_compare_arbiter: one early-exit and one full-width instance
// share the same stimulus. Each instance has its own reference model and
// result monitor.
module tb_serial_compare_arbiter;

    localparam int W = 16;

    typedef struct {
        logic id;
        logic lt;
        logic eq;
        logic gt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req1_valid = 1'b0;
    logic         res_ready  = 1'b1;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;

    logic r0_rdy [2];
    logic r1_rdy [2];
    logic rv     [2];
    logic rid    [2];
    logic rl     [2];
    logic re     [2];
    logic rg     [2];
    logic bsy    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_compare_arbiter #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_rdy[0]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1_rdy[0]), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(rv[0]), .res_ready(res_ready), .res_id(rid[0]),
        .res_less(rl[0]), .res_eq(re[0]), .res_greater(rg[0]), .busy(bsy[0])
    );

    serial_compare_arbiter #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_rdy[1]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1_rdy[1]), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(rv[1]), .res_ready(res_ready), .res_id(rid[1]),
        .res_less(rl[1]), .res_eq(re[1]), .res_greater(rg[1]), .busy(bsy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycles from the accept edge to the edge after which the result shows
    function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
        if (!ee || a == b) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return W - i;
        end
        return W;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_chk
        localparam bit EE = (g == 0);
        exp_t sb[$];
        int   phase = 0;      // 0 idle, 1 comparing, 2 result pending
        int   rem   = 0;
        logic last  = 1'b1;
        logic prev_rv  = 1'b0;
        logic prev_rdy = 1'b0;
        logic [3:0] prev_out = '0;

        // Reference model: arbitration, timing and the expected result per accept
        always @(negedge clk) begin : model
            bit         gv;
            logic       gid;
            logic [W-1:0] a;
            logic [W-1:0] b;
            exp_t       e;
            if (rst) begin
                phase = 0;
                last  = 1'b1;
                sb.delete();
            end
            gv  = req0_valid | req1_valid;
            gid = (req0_valid && req1_valid) ? ~last : req1_valid;
            chk($sformatf("ee%0d_busy", EE), bsy[g], phase != 0);
            chk($sformatf("ee%0d_res_valid", EE), rv[g], phase == 2);
            chk($sformatf("ee%0d_req0_ready", EE), r0_rdy[g], (phase == 0) && gv && !gid);
            chk($sformatf("ee%0d_req1_ready", EE), r1_rdy[g], (phase == 0) && gv && gid);
            if (!rst) begin
                case (phase)
                    0: if (gv) begin
                        a = gid ? req1_a : req0_a;
                        b = gid ? req1_b : req0_b;
                        e.id = gid;
                        e.lt = a < b;
                        e.eq = a == b;
                        e.gt = a > b;
                        sb.push_back(e);
                        last  = gid;
                        rem   = latency(a, b, EE);
                        phase = 1;
                    end
                    1: begin
                        rem--;
                        if (rem == 0) phase = 2;
                    end
                    default: if (res_ready) phase = 0;
                endcase
            end
        end

        // Result monitor: compares each presented result against the scoreboard
        always @(negedge clk) begin : monitor
            logic [3:0] out;
            out = {rid[g], rl[g], re[g], rg[g]};
            if (rst) begin
                prev_rv = 1'b0;
            end else begin
                if (rv[g]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("ee%0d_unexpected_result", EE), rv[g], 1'b0);
                    end else begin
                        chk($sformatf("ee%0d_res_id", EE), rid[g], sb[0].id);
                        chk($sformatf("ee%0d_res_less", EE), rl[g], sb[0].lt);
                        chk($sformatf("ee%0d_res_eq", EE), re[g], sb[0].eq);
                        chk($sformatf("ee%0d_res_greater", EE), rg[g], sb[0].gt);
                        if (prev_rv && !prev_rdy)
                            chk($sformatf("ee%0d_hold_stable", EE), out, prev_out);
                        if (res_ready) void'(sb.pop_front());
                    end
                end else begin
                    chk($sformatf("ee%0d_res_zero", EE), out, 4'h0);
                end
                prev_rv  = rv[g];
                prev_rdy = res_ready;
                prev_out = out;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic rnd_pair(output logic [W-1:0] a, output logic [W-1:0] b);
        a = W'($urandom);
        case ($urandom_range(0, 4))
            0: b = a;
            1: b = a ^ (W'(1) << $urandom_range(0, W - 1));
            2: begin
                a = 16'h8000;
                b = 16'h7FFF;
                if ($urandom_range(0, 1) == 1) begin
                    a = 16'h7FFF;
                    b = 16'h8000;
                end
            end
            default: b = W'($urandom);
        endcase
    endtask

    task automatic rnd_both();
        rnd_pair(req0_a, req0_b);
        rnd_pair(req1_a, req1_b);
    endtask

    initial begin
        repeat (3) next_cycle();
        rst = 1'b0;

        // First difference at bit 10: 6 cycles early-exit, 16 otherwise
        req0_valid = 1'b1; req0_a = 16'h4126; req0_b = 16'h4646;
        next_cycle();
        idle(20);

        // Equal pair through requester 1
        req1_valid = 1'b1; req1_a = 16'h4726; req1_b = 16'h4726;
        next_cycle();
        idle(20);

        // MSB-only difference
        req0_valid = 1'b1; req0_a = 16'h8000; req0_b = 16'h7FFF;
        next_cycle();
        idle(20);

        // Both requesters valid continuously: grants must alternate
        res_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            rnd_both();
            next_cycle();
        end
        idle(20);

        // Result backpressure while the requester bus keeps changing
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h1110;
        next_cycle();
        req0_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rnd_both();
            next_cycle();
        end
        res_ready = 1'b1;
        idle(20);

        // Reset in the middle of a compare (counter at 9)
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1234;
        next_cycle();
        req0_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy_%0d", d), bsy[d], 1'b0);
            chk($sformatf("rst_res_valid_%0d", d), rv[d], 1'b0);
        end
        req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F00;
        req1_valid = 1'b1; req1_a = 16'hF000; req1_b = 16'h0F00;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        for (int i = 0; i < 40; i++) begin
            rnd_both();
            next_cycle();
        end
        idle(20);

        // Randomized traffic with random backpressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            res_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 499) == 0);
            rnd_both();
            next_cycle();
        end
        rst = 1'b0;
        res_ready = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
